// File: rtl/perimeter_arbiter.sv
// Round-robin arbiter: two dav_/rfd producers share one consumer, one word in flight at a time.
// Define PERIMETER_ARB_FIXED_PRIO_EN for fixed priority (producer 1 always wins a tie).
module perimeter_arbiter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] data_in_1,
  input  logic         dav_in_1_,
  output logic         rfd_in_1,
  input  logic [W-1:0] data_in_2,
  input  logic         dav_in_2_,
  output logic         rfd_in_2,
  output logic [W-1:0] data_out,
  output logic         src_out,
  output logic         dav_out_,
  input  logic         rfd_out
);

  typedef enum logic [1:0] {IDLE, IN_ACK, OUT_WAIT, OUT_VALID} state_t;

  state_t         state, state_nx;
  logic           rfd_in_1_nx, rfd_in_2_nx, dav_out_nx, src_out_nx;
  logic [W-1:0]   data_out_nx;
  logic           pick_2;
  logic           dav_granted_;

`ifdef PERIMETER_ARB_FIXED_PRIO_EN
  assign pick_2 = ~dav_in_2_ & dav_in_1_;
`else
  // last_2 set means producer 2 was served last, so producer 1 wins the next tie.
  logic last_2, last_2_nx;
  assign pick_2 = ~dav_in_2_ & (dav_in_1_ | ~last_2);
`endif

  // src_out is only rewritten at grant, so it doubles as the granted-producer index.
  assign dav_granted_ = src_out ? dav_in_2_ : dav_in_1_;

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    rfd_in_1_nx = rfd_in_1;
    rfd_in_2_nx = rfd_in_2;
    dav_out_nx  = dav_out_;
    src_out_nx  = src_out;
    data_out_nx = data_out;
`ifndef PERIMETER_ARB_FIXED_PRIO_EN
    last_2_nx   = last_2;
`endif
    unique case (state)
      IDLE: begin
        if (!dav_in_1_ || !dav_in_2_) begin
          data_out_nx = pick_2 ? data_in_2 : data_in_1;
          src_out_nx  = pick_2;
          if (pick_2) rfd_in_2_nx = 1'b0;
          else        rfd_in_1_nx = 1'b0;
`ifndef PERIMETER_ARB_FIXED_PRIO_EN
          last_2_nx   = pick_2;
`endif
          state_nx    = IN_ACK;
        end
      end
      IN_ACK: begin
        if (dav_granted_) begin
          if (src_out) rfd_in_2_nx = 1'b1;
          else         rfd_in_1_nx = 1'b1;
          state_nx = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (rfd_out) begin
          dav_out_nx = 1'b0;
          state_nx   = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (!rfd_out) begin
          dav_out_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rfd_in_1 <= 1'b1;
      rfd_in_2 <= 1'b1;
      dav_out_ <= 1'b1;
      src_out  <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_nx;
      rfd_in_1 <= rfd_in_1_nx;
      rfd_in_2 <= rfd_in_2_nx;
      dav_out_ <= dav_out_nx;
      src_out  <= src_out_nx;
      data_out <= data_out_nx;
    end
  end

`ifndef PERIMETER_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock) begin
    if (reset) last_2 <= 1'b1;
    else       last_2 <= last_2_nx;
  end
`endif

endmodule
